keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 68 ++++++
 tb/tb_keypad_scanner.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with one-hot column strobe and key encoding
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   row       : debounced row lines, active-high
//   col       : one-hot column strobe
//   key_code  : last detected key {row_idx, col_idx}
//   key_valid : one-cycle pulse when key_code is newly updated
//   key_held  : high while the detected key is still pressed
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int CNTW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  typedef enum logic {SCAN, HOLD} state_t;
  localparam logic [CNTW-1:0] LAST = CNTW'(SCAN_DIV - 1);
  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [3:0]      col_q, col_d, code_q, code_d;
  logic            valid_q, valid_d, held_q, held_d;
  logic            sample, hit, det;
  logic [1:0]      r_idx, c_idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SCAN;
    else     state_q <= state_d;
  end
  // Rows only matter at the sample point; a held key keeps HOLD, an empty column ends it.
  always_comb begin
    sample  = cnt_q == LAST;
    hit     = |row;
    state_d = sample ? (hit ? HOLD : SCAN) : state_q;
  end
  always_comb begin
    r_idx   = row[0] ? 2'd0 : row[1] ? 2'd1 : row[2] ? 2'd2 : 2'd3;
    c_idx   = col_q[1] ? 2'd1 : col_q[2] ? 2'd2 : col_q[3] ? 2'd3 : 2'd0;
    det     = sample && hit && state_q == SCAN;
    cnt_d   = sample ? '0 : cnt_q + CNTW'(1);
    col_d   = (sample && !hit) ? {col_q[2:0], col_q[3]} : col_q;
    code_d  = det ? {r_idx, c_idx} : code_q;
    valid_d = det;
    held_d  = sample ? hit : held_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      col_q   <= 4'b0001;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end
  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad matrix stimulus checked against a cycle-counting reference model
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  logic       clk = 0;
  logic       rst = 1;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;
  logic [3:0] pressed [4];
  int n_assert = 0;
  int n_fail   = 0;
  int m_n, m_ci;
  logic       m_hold, m_valid, m_held;
  logic [3:0] m_code;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  assign row = {|(pressed[3] & col), |(pressed[2] & col), |(pressed[1] & col), |(pressed[0] & col)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_ci = 0; m_hold = 0; m_valid = 0; m_held = 0; m_code = 0;
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".col"}, 32'(col), 32'(4'b0001 << m_ci));
    chk({tag, ".code"}, 32'(key_code), 32'(m_code));
    chk({tag, ".valid"}, 32'(key_valid), 32'(m_valid));
    chk({tag, ".held"}, 32'(key_held), 32'(m_held));
  endtask

  // Every SCAN_DIV-th edge after reset is a sample point; the model tracks only the
  // active column index, whether a key is latched, and the visible outputs.
  task automatic step(input string tag);
    logic [3:0] rows;
    int lr;
    for (int r = 0; r < 4; r++) rows[r] = pressed[r][m_ci];
    m_valid = 0;
    if (m_n % SCAN_DIV == SCAN_DIV - 1) begin
      if (rows != 0 && !m_hold) begin
        lr = 0;
        for (int r = 3; r >= 0; r--) if (rows[r]) lr = r;
        m_code = 4'((lr << 2) | m_ci);
        m_valid = 1; m_held = 1; m_hold = 1;
      end else if (rows == 0) begin
        m_hold = 0; m_held = 0;
        m_ci = (m_ci + 1) % 4;
      end
    end
    m_n++;
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    int guard;
    clear_keys();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 0;
    run("idle", 24);

    pressed[2][1] = 1'b1;
    run("press_r2c1", 24);
    chk("press_r2c1.code_const", 32'(key_code), 32'd9);
    pressed[2][1] = 1'b0;
    run("release_r2c1", 12);
    chk("release.code_kept", 32'(key_code), 32'd9);

    pressed[1][3] = 1'b1; pressed[3][3] = 1'b1;
    run("multirow", 24);
    chk("multirow.code_const", 32'(key_code), 32'h7);
    clear_keys();
    run("multirow_rel", 20);

    pressed[0][0] = 1'b1;
    run("hold_r0c0", 20);
    pressed[2][2] = 1'b1;
    run("hold_both", 16);
    pressed[0][0] = 1'b0;
    run("second_key", 24);
    chk("second_key.code_const", 32'(key_code), 32'hA);
    clear_keys();
    run("second_rel", 16);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        int r, c;
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        pressed[r][c] = ~pressed[r][c];
      end
      if ($urandom_range(0, 99) == 0) clear_keys();
      step("random");
    end
    clear_keys();
    run("drain", 20);

    pressed[1][1] = 1'b1;
    guard = 0;
    while (!m_held && guard < 40) begin
      step("to_hold");
      guard++;
    end
    chk("to_hold.reached", 32'(m_held), 32'd1);
    #2 rst = 1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk); #1;
    check_outputs("async_rst_hold");
    @(negedge clk);
    rst = 0;
    run("after_rst", 24);
    clear_keys();
    run("final", 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
